seq_grant_fsm: RTL and testbench
================================

SEQ_GRANT_FSM -- requirements
Module: seq_grant_fsm

Interface
REQ-001 SHALL have parameter PAT_LEN, default 3: length of the x pattern in samples (legal range 1..16).
REQ-002 SHALL have parameter PATTERN, default 3'b101, PAT_LEN bits wide: PATTERN[PAT_LEN-1] is the first sample expected and PATTERN[0] the last.
REQ-003 SHALL have parameter Y_WIN, default 2: number of y-sampling edges allowed after a pattern match (legal range 1..255).
REQ-004 SHALL have parameter F_CYCLES, default 1: f pulse length in cycles (legal range 1..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port x, input, 1 bit: pattern stream, sampled on clk edges in SEARCH only.
REQ-008 SHALL have port y, input, 1 bit: grant-confirm input, sampled on clk edges in GWAIT only.
REQ-009 SHALL have port rearm, input, 1 bit: return-to-search request, honoured in GHOLD and GOFF only.
REQ-010 SHALL have port f, output, 1 bit: start pulse.
REQ-011 SHALL have port g, output, 1 bit: grant.
REQ-012 SHALL have port state, output, 3 bits: current state code.

Function
REQ-013 SHALL use the state codes IDLE=0, FPULSE=1, SEARCH=2, GWAIT=3, GHOLD=4, GOFF=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-014 SHALL decode f, g and state from flops only (Moore), with no combinational path from x, y or rearm to any output.
REQ-015 SHALL go from IDLE to FPULSE on the first rising edge with resetn high.
REQ-016 SHALL hold f=1 only in FPULSE, for exactly F_CYCLES cycles counted by a 4-bit counter, then move to SEARCH; x is ignored during FPULSE.
REQ-017 SHALL, on SEARCH entry, clear a PAT_LEN-bit history register and a saturating sample counter.
REQ-018 SHALL, on each edge while in SEARCH, shift x into the history LSB.
REQ-019 SHALL detect a match when {history[PAT_LEN-2:0], x} equals PATTERN and at least PAT_LEN-1 samples were already taken since SEARCH entry.
REQ-020 SHALL move to GWAIT on the edge at which a match is detected.
REQ-021 SHALL match overlapping occurrences, so that with PATTERN=101 the stream 1,1,0,1 matches on the 4th sample.
REQ-022 SHALL drive g=1 in GWAIT, where an 8-bit counter counts y-sampling edges.
REQ-023 SHALL move from GWAIT to GHOLD on the first GWAIT edge with y=1.
REQ-024 SHALL move from GWAIT to GOFF when the Y_WIN-th GWAIT edge has y=0; g is therefore high for Y_WIN cycles in that case.
REQ-025 SHALL hold g=1 in GHOLD and g=0 in GOFF, with x and y ignored in both.
REQ-026 SHALL move from GHOLD or GOFF to SEARCH on an edge with rearm=1, with no f pulse and with history cleared.
REQ-027 SHALL ignore rearm in every state other than GHOLD and GOFF.
REQ-028 SHALL drive f=0 and g=0 in IDLE and SEARCH; f and g SHALL never both be 1.

Reset
REQ-029 SHALL, while resetn=0, force state=IDLE, f=0, g=0, and all counters and history to 0, asynchronously and without waiting for clk.
REQ-030 SHALL, on resetn deassertion, act on the next rising edge per REQ-015; reset mid-operation in any state SHALL abort that operation with no retained history.

Verification
REQ-031 SHALL be verified, with defaults, by: resetn low for 2 edges then high, x=y=0 -> f=1 for exactly 1 cycle after the first edge, then f=0; state=2; g stays 0.
REQ-032 SHALL be verified, with defaults, by: x=1,0,1 on successive SEARCH edges then y=1 on the first GWAIT edge -> g=1 from the cycle after the 3rd sample and held (state=4) for 20+ cycles of random x/y.
REQ-033 SHALL be verified, with defaults, by: x=1,1,0,1 -> match after the 4th sample; x=1,0,0,1,0 -> no match and state stays 2.
REQ-034 SHALL be verified, with defaults, by: match then y=0 for 2 GWAIT edges -> g=1 for 2 cycles then g=0 and state=5; later y=1 has no effect; rearm=1 -> state=2, g=0, and a full new pattern is required.
REQ-035 SHALL be verified by: resetn pulled low between edges while in GHOLD -> g=0 and state=0 before the next edge; after release the f pulse repeats.
REQ-036 SHALL be verified by: PAT_LEN=4, PATTERN=4'b0110, Y_WIN=3, F_CYCLES=2 -> f high for 2 cycles; x=0,1,1,0 matches; y=1 on the 3rd GWAIT edge -> GHOLD; y=0 on all 3 GWAIT edges -> GOFF.

Source files
------------

// File: rtl/seq_grant_fsm.sv
// Pattern-triggered grant sequencer: start pulse, serial pattern search on x,
// then a y-confirmed grant window with hold/off states and rearm back to search.
module seq_grant_fsm #(
   parameter int                PAT_LEN  = 3,
   parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
   parameter int                Y_WIN    = 2,
   parameter int                F_CYCLES = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       x,
   input  logic       y,
   input  logic       rearm,
   output logic       f,
   output logic       g,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FPULSE = 3'd1,
      SEARCH = 3'd2,
      GWAIT  = 3'd3,
      GHOLD  = 3'd4,
      GOFF   = 3'd5
   } state_t;

   localparam logic [3:0] F_LAST    = 4'(F_CYCLES - 1);
   localparam logic [7:0] Y_LAST    = 8'(Y_WIN - 1);
   localparam logic [4:0] SAMP_NEED = 5'(PAT_LEN - 1);

   state_t             state_reg, state_next;
   logic [3:0]         f_cnt_reg, f_cnt_next;
   logic [7:0]         y_cnt_reg, y_cnt_next;
   logic [4:0]         samp_cnt_reg, samp_cnt_next;
   logic [PAT_LEN-1:0] hist_reg, hist_next;
   logic [PAT_LEN-1:0] shifted;
   logic               match;

   // Candidate window is the stored history with the current sample appended,
   // so overlapping occurrences are found without any restart logic.
   assign shifted = (hist_reg << 1) | PAT_LEN'(x);
   assign match   = (shifted == PATTERN) && (samp_cnt_reg >= SAMP_NEED);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= IDLE;
         f_cnt_reg    <= '0;
         y_cnt_reg    <= '0;
         samp_cnt_reg <= '0;
         hist_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         f_cnt_reg    <= f_cnt_next;
         y_cnt_reg    <= y_cnt_next;
         samp_cnt_reg <= samp_cnt_next;
         hist_reg     <= hist_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      f_cnt_next    = f_cnt_reg;
      y_cnt_next    = y_cnt_reg;
      samp_cnt_next = samp_cnt_reg;
      hist_next     = hist_reg;
      case (state_reg)
         IDLE: begin
            state_next = FPULSE;
            f_cnt_next = '0;
         end
         FPULSE: begin
            if (f_cnt_reg == F_LAST) begin
               state_next    = SEARCH;
               hist_next     = '0;
               samp_cnt_next = '0;
            end else begin
               f_cnt_next = f_cnt_reg + 4'd1;
            end
         end
         SEARCH: begin
            hist_next = shifted;
            if (samp_cnt_reg != 5'd31) samp_cnt_next = samp_cnt_reg + 5'd1;
            if (match) begin
               state_next = GWAIT;
               y_cnt_next = '0;
            end
         end
         GWAIT: begin
            if (y) begin
               state_next = GHOLD;
            end else if (y_cnt_reg == Y_LAST) begin
               state_next = GOFF;
            end else begin
               y_cnt_next = y_cnt_reg + 8'd1;
            end
         end
         GHOLD, GOFF: begin
            if (rearm) begin
               state_next    = SEARCH;
               hist_next     = '0;
               samp_cnt_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign f     = (state_reg == FPULSE);
   assign g     = (state_reg == GWAIT) || (state_reg == GHOLD);
   assign state = state_reg;

endmodule

// File: tb/tb_seq_grant_fsm.sv
// Directed bench: default-parameter instance d0 and a 4-bit-pattern instance d1.
module tb_seq_grant_fsm;
   logic       clk;
   logic       resetn0, x0, y0, rearm0, f0, g0;
   logic [2:0] state0;
   logic       resetn1, x1, y1, rearm1, f1, g1;
   logic [2:0] state1;
   int         checks;
   int         errors;

   seq_grant_fsm d0 (
      .clk(clk), .resetn(resetn0), .x(x0), .y(y0), .rearm(rearm0),
      .f(f0), .g(g0), .state(state0)
   );

   seq_grant_fsm #(.PAT_LEN(4), .PATTERN(4'b0110), .Y_WIN(3), .F_CYCLES(2)) d1 (
      .clk(clk), .resetn(resetn1), .x(x1), .y(y1), .rearm(rearm1),
      .f(f1), .g(g1), .state(state1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk0(input string tag, input logic [2:0] st, input logic ef, input logic eg);
      chk({tag, ".state"}, 8'(state0), 8'(st));
      chk({tag, ".f"}, 8'(f0), 8'(ef));
      chk({tag, ".g"}, 8'(g0), 8'(eg));
   endtask

   task automatic chk1(input string tag, input logic [2:0] st, input logic ef, input logic eg);
      chk({tag, ".state"}, 8'(state1), 8'(st));
      chk({tag, ".f"}, 8'(f1), 8'(ef));
      chk({tag, ".g"}, 8'(g1), 8'(eg));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      resetn0 = 1'b0; x0 = 1'b0; y0 = 1'b0; rearm0 = 1'b0;
      resetn1 = 1'b0; x1 = 1'b0; y1 = 1'b0; rearm1 = 1'b0;

      // reset held for two edges, then start pulse of one cycle
      tick(); tick();
      chk0("reset", 3'd0, 1'b0, 1'b0);
      resetn0 = 1'b1;
      tick(); chk0("fpulse", 3'd1, 1'b1, 1'b0);
      tick(); chk0("search_entry", 3'd2, 1'b0, 1'b0);
      tick(); chk0("search_idle", 3'd2, 1'b0, 1'b0);

      // 1,0,1 then y=1 on first GWAIT edge, grant held under random x/y
      x0 = 1'b1; tick(); chk0("p101_s1", 3'd2, 1'b0, 1'b0);
      x0 = 1'b0; tick(); chk0("p101_s2", 3'd2, 1'b0, 1'b0);
      x0 = 1'b1; tick(); chk0("p101_match", 3'd3, 1'b0, 1'b1);
      y0 = 1'b1; tick(); chk0("ghold", 3'd4, 1'b0, 1'b1);
      for (int i = 0; i < 22; i++) begin
         x0 = 1'($urandom_range(0, 1));
         y0 = 1'($urandom_range(0, 1));
         tick(); chk0("ghold_rand", 3'd4, 1'b0, 1'b1);
      end
      x0 = 1'b0; y0 = 1'b0; rearm0 = 1'b1;
      tick(); chk0("rearm_hold", 3'd2, 1'b0, 1'b0);
      rearm0 = 1'b0;

      // overlapping 1,1,0,1 matches on the 4th sample
      x0 = 1'b1; tick(); chk0("ov_s1", 3'd2, 1'b0, 1'b0);
      x0 = 1'b1; tick(); chk0("ov_s2", 3'd2, 1'b0, 1'b0);
      x0 = 1'b0; tick(); chk0("ov_s3", 3'd2, 1'b0, 1'b0);
      x0 = 1'b1; tick(); chk0("ov_match", 3'd3, 1'b0, 1'b1);

      // y=0 for the whole window: g high 2 cycles, then GOFF ignores y
      x0 = 1'b0; y0 = 1'b0;
      tick(); chk0("gwait_y0_1", 3'd3, 1'b0, 1'b1);
      tick(); chk0("goff", 3'd5, 1'b0, 1'b0);
      y0 = 1'b1; x0 = 1'b1;
      tick(); chk0("goff_y1", 3'd5, 1'b0, 1'b0);
      y0 = 1'b0; rearm0 = 1'b1;
      tick(); chk0("rearm_off", 3'd2, 1'b0, 1'b0);
      rearm0 = 1'b0;

      // stale history would complete 1,0,1 here; cleared history must not
      x0 = 1'b0; tick(); chk0("fresh_s1", 3'd2, 1'b0, 1'b0);
      x0 = 1'b1; tick(); chk0("fresh_s2", 3'd2, 1'b0, 1'b0);
      x0 = 1'b0; tick(); chk0("fresh_s3", 3'd2, 1'b0, 1'b0);
      x0 = 1'b1; tick(); chk0("fresh_match", 3'd3, 1'b0, 1'b1);
      y0 = 1'b1; tick(); chk0("fresh_hold", 3'd4, 1'b0, 1'b1);
      y0 = 1'b0; rearm0 = 1'b1;
      tick(); chk0("rearm2", 3'd2, 1'b0, 1'b0);
      rearm0 = 1'b0;

      // 1,0,0,1,0 never matches
      x0 = 1'b1; tick(); chk0("nm_s1", 3'd2, 1'b0, 1'b0);
      x0 = 1'b0; tick(); chk0("nm_s2", 3'd2, 1'b0, 1'b0);
      x0 = 1'b0; tick(); chk0("nm_s3", 3'd2, 1'b0, 1'b0);
      x0 = 1'b1; tick(); chk0("nm_s4", 3'd2, 1'b0, 1'b0);
      x0 = 1'b0; tick(); chk0("nm_s5", 3'd2, 1'b0, 1'b0);

      // history ends 1,0 so a single 1 completes an overlapping match
      x0 = 1'b1; tick(); chk0("ov2_match", 3'd3, 1'b0, 1'b1);
      y0 = 1'b1; x0 = 1'b0; tick(); chk0("ov2_hold", 3'd4, 1'b0, 1'b1);

      // asynchronous reset between edges while in GHOLD
      #2 resetn0 = 1'b0;
      #1 chk0("async_reset", 3'd0, 1'b0, 1'b0);
      y0 = 1'b0;
      tick(); chk0("reset_held", 3'd0, 1'b0, 1'b0);
      resetn0 = 1'b1;
      tick(); chk0("refpulse", 3'd1, 1'b1, 1'b0);
      tick(); chk0("research", 3'd2, 1'b0, 1'b0);

      // instance d1: PAT_LEN=4, PATTERN=0110, Y_WIN=3, F_CYCLES=2
      chk1("d1_reset", 3'd0, 1'b0, 1'b0);
      resetn1 = 1'b1;
      tick(); chk1("d1_f1", 3'd1, 1'b1, 1'b0);
      tick(); chk1("d1_f2", 3'd1, 1'b1, 1'b0);
      tick(); chk1("d1_search", 3'd2, 1'b0, 1'b0);
      x1 = 1'b0; tick(); chk1("d1_a_s1", 3'd2, 1'b0, 1'b0);
      x1 = 1'b1; tick(); chk1("d1_a_s2", 3'd2, 1'b0, 1'b0);
      x1 = 1'b1; tick(); chk1("d1_a_s3", 3'd2, 1'b0, 1'b0);
      x1 = 1'b0; tick(); chk1("d1_a_match", 3'd3, 1'b0, 1'b1);
      y1 = 1'b0; tick(); chk1("d1_a_w1", 3'd3, 1'b0, 1'b1);
      y1 = 1'b0; tick(); chk1("d1_a_w2", 3'd3, 1'b0, 1'b1);
      y1 = 1'b1; tick(); chk1("d1_a_hold", 3'd4, 1'b0, 1'b1);
      y1 = 1'b0; rearm1 = 1'b1;
      tick(); chk1("d1_rearm", 3'd2, 1'b0, 1'b0);
      rearm1 = 1'b0;
      x1 = 1'b0; tick(); chk1("d1_b_s1", 3'd2, 1'b0, 1'b0);
      x1 = 1'b1; tick(); chk1("d1_b_s2", 3'd2, 1'b0, 1'b0);
      x1 = 1'b1; tick(); chk1("d1_b_s3", 3'd2, 1'b0, 1'b0);
      x1 = 1'b0; tick(); chk1("d1_b_match", 3'd3, 1'b0, 1'b1);
      tick(); chk1("d1_b_w1", 3'd3, 1'b0, 1'b1);
      tick(); chk1("d1_b_w2", 3'd3, 1'b0, 1'b1);
      tick(); chk1("d1_b_off", 3'd5, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
